// File: rtl/qpp_pkg.sv
// Shared constants, FSM state type and the modular add used by the QPP
// address recursion of the extrinsic interleaver.
package qpp_pkg;

    localparam int MAX_K = 6144;
    localparam int W     = 16;
    localparam int AW    = 13;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    // (a + b) mod k for a, b < k; the sum needs one extra bit before the subtract.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW:0]   k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= k) begin
            s = s - k;
        end
        return s[AW-1:0];
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// QPP address generator: pi(i) = f1*i + f2*i^2 mod K, produced one step at a
// time from a running increment g(i), so no multiplier is needed.
module qpp_addr_gen
    import qpp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [AW:0]   K,
    input  logic [AW-1:0] g0,
    input  logic [AW-1:0] g2,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] g_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            g_q  <= '0;
        end else if (start) begin
            addr <= '0;
            g_q  <= g0;
        end else if (step) begin
            addr <= mod_add(addr, g_q, K);
            g_q  <= mod_add(g_q, g2, K);
        end
    end

endmodule

// File: rtl/extrinsic_interleaver.sv
// Captures one K-sample extrinsic frame into a block RAM and replays it in QPP
// interleaved (mode 0) or deinterleaved (mode 1) order as the next apriori stream.
//
// state | meaning
// IDLE  | waiting for a config strobe; config is checked here
// LOAD  | writing incoming extrinsic samples, K writes expected
// DRAIN | reading the RAM out through a 2-entry skid to apriori
module extrinsic_interleaver
    import qpp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   blklen,
    input  logic [15:0]   f1,
    input  logic [15:0]   f2,
    input  logic          mode,
    input  logic          valid_blklen,
    input  logic [W-1:0]  extrinsic,
    input  logic          valid_extrinsic,
    output logic [W-1:0]  apriori,
    output logic          valid_apriori,
    input  logic          apriori_ready,
    output logic          apriori_last,
    output logic          busy,
    output logic          cfg_err
);

    localparam logic [15:0] MAX_K16 = 16'(MAX_K);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   k_q, cnt_q, k_m1;
    logic [AW-1:0] g0_q, g2_q, new_g0, new_g2;
    logic          mode_q;
    logic          cfg_bad, cfg_ok;
    logic [AW:0]   gen_k;
    logic [AW-1:0] gen_g0, gen_g2, pi;
    logic          gen_start, gen_step;
    logic          wr_en, load_done, rd_en, rd_is_last, pop;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    used;

    logic [W-1:0]  mem [MAX_K];
    logic [W-1:0]  rd_q, pf_q;
    logic          rd_vld_q, rd_last_q, pf_vld_q, pf_last_q;

    assign cfg_bad = (blklen == 16'd0) || (blklen > MAX_K16) || (blklen[2:0] != 3'd0)
                  || (f1 >= blklen) || (f2 >= blklen);
    assign cfg_ok  = (state_q == IDLE) && valid_blklen && !cfg_bad;
    assign new_g2  = mod_add(f2[AW-1:0], f2[AW-1:0], blklen[AW:0]);
    assign new_g0  = mod_add(f1[AW-1:0], f2[AW-1:0], blklen[AW:0]);

    assign k_m1      = k_q - ONE;
    assign wr_en     = (state_q == LOAD) && valid_extrinsic;
    assign load_done = wr_en && (cnt_q == k_m1);
    assign pop       = valid_apriori && apriori_ready;

    // Reads are issued only when the skid is guaranteed room for the returning word.
    assign used       = {1'b0, valid_apriori} + {1'b0, pf_vld_q} + {1'b0, rd_vld_q};
    assign rd_en      = (state_q == DRAIN) && (cnt_q != k_q)
                     && ((used < 2'd2) || (pop && (used == 2'd2)));
    assign rd_is_last = (cnt_q == k_m1);

    // On config accept the generator restarts from the incoming values directly.
    assign gen_start = cfg_ok || load_done;
    assign gen_step  = wr_en || rd_en;
    assign gen_k     = cfg_ok ? blklen[AW:0] : k_q;
    assign gen_g0    = cfg_ok ? new_g0 : g0_q;
    assign gen_g2    = cfg_ok ? new_g2 : g2_q;

    assign wr_addr = mode_q ? pi : cnt_q[AW-1:0];
    assign rd_addr = mode_q ? cnt_q[AW-1:0] : pi;
    assign busy    = (state_q != IDLE);

    qpp_addr_gen u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .start (gen_start),
        .step  (gen_step),
        .K     (gen_k),
        .g0    (gen_g0),
        .g2    (gen_g2),
        .addr  (pi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_ok)                  state_d = LOAD;
            LOAD:    if (load_done)               state_d = DRAIN;
            DRAIN:   if (pop && apriori_last)     state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            g0_q    <= '0;
            g2_q    <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            if ((state_q == IDLE) && valid_blklen) begin
                cfg_err <= cfg_bad;
            end
            if (cfg_ok) begin
                k_q    <= blklen[AW:0];
                g0_q   <= new_g0;
                g2_q   <= new_g2;
                mode_q <= mode;
                cnt_q  <= '0;
            end else if (load_done) begin
                cnt_q <= '0;
            end else if (wr_en || rd_en) begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= extrinsic;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Output register fed from the skid first, then straight from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q      <= 1'b0;
            rd_last_q     <= 1'b0;
            pf_q          <= '0;
            pf_vld_q      <= 1'b0;
            pf_last_q     <= 1'b0;
            apriori       <= '0;
            valid_apriori <= 1'b0;
            apriori_last  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_last_q <= rd_is_last;
            end
            if (!valid_apriori || pop) begin
                if (pf_vld_q) begin
                    apriori       <= pf_q;
                    apriori_last  <= pf_last_q;
                    valid_apriori <= 1'b1;
                    pf_vld_q      <= rd_vld_q;
                    if (rd_vld_q) begin
                        pf_q      <= rd_q;
                        pf_last_q <= rd_last_q;
                    end
                end else if (rd_vld_q) begin
                    apriori       <= rd_q;
                    apriori_last  <= rd_last_q;
                    valid_apriori <= 1'b1;
                end else begin
                    valid_apriori <= 1'b0;
                    apriori_last  <= 1'b0;
                end
            end else if (rd_vld_q) begin
                pf_q      <= rd_q;
                pf_last_q <= rd_last_q;
                pf_vld_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_extrinsic_interleaver.sv
// Bench for extrinsic_interleaver: directed frames checked against a
// permutation model computed directly from pi(j) = (f1*j + f2*j^2) mod K.
module tb_extrinsic_interleaver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] blklen = '0, f1 = '0, f2 = '0;
    logic        mode = 1'b0, valid_blklen = 1'b0;
    logic [15:0] extrinsic = '0;
    logic        valid_extrinsic = 1'b0;
    logic [15:0] apriori;
    logic        valid_apriori, apriori_ready = 1'b1, apriori_last, busy, cfg_err;

    extrinsic_interleaver dut (
        .clk             (clk),
        .rst             (rst),
        .blklen          (blklen),
        .f1              (f1),
        .f2              (f2),
        .mode            (mode),
        .valid_blklen    (valid_blklen),
        .extrinsic       (extrinsic),
        .valid_extrinsic (valid_extrinsic),
        .apriori         (apriori),
        .valid_apriori   (valid_apriori),
        .apriori_ready   (apriori_ready),
        .apriori_last    (apriori_last),
        .busy            (busy),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] out_log[$];
    logic [15:0] din [6144];
    logic [15:0] mdl [6144];
    logic        seen [6144];
    int          n_checks = 0;
    int          n_errors = 0;

    logic        held_v = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_l = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qpp(input int j, input int k, input int a, input int b);
        longint t;
        t = longint'(a) * j + longint'(b) * j * j;
        return int'(t % k);
    endfunction

    // Mode 0 reads x[pi(j)]; mode 1 scatters x[i] to pi(i) then reads linearly.
    task automatic build_expected(input int k, input int a, input int b, input logic m);
        exp_t e;
        if (m == 1'b0) begin
            for (int j = 0; j < k; j++) begin
                e.d = din[qpp(j, k, a, b)];
                e.l = (j == k - 1);
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < k; i++) mdl[qpp(i, k, a, b)] = din[i];
            for (int j = 0; j < k; j++) begin
                e.d = mdl[j];
                e.l = (j == k - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", valid_apriori, 1);
                chk("stall_data", apriori, held_d);
                chk("stall_last", apriori_last, held_l);
            end
            held_v = valid_apriori && !apriori_ready;
            held_d = apriori;
            held_l = apriori_last;
            if (valid_apriori && apriori_ready) begin
                chk("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("apriori_data", apriori, e.d);
                    chk("apriori_last", apriori_last, e.l);
                end
                out_log.push_back(apriori);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_apriori"}, apriori, 0);
        chk({tag, "_valid"}, valid_apriori, 0);
        chk({tag, "_last"}, apriori_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        exp_q.delete();
        step();
        check_reset_vals(tag);
        rst = 1'b0;
        step();
    endtask

    task automatic load_frame(input int k, input int a, input int b, input logic m,
                              input logic gap, input logic noise, input int nload);
        build_expected(k, a, b, m);
        out_log.delete();
        if (noise) begin
            valid_extrinsic = 1'b1;
            extrinsic = 16'h7777;
            step();
            valid_extrinsic = 1'b0;
        end
        blklen = 16'(k);
        f1 = 16'(a);
        f2 = 16'(b);
        mode = m;
        valid_blklen = 1'b1;
        step();
        valid_blklen = 1'b0;
        chk("cfg_busy", busy, 1);
        chk("cfg_err_clear", cfg_err, 0);
        for (int i = 0; i < nload; i++) begin
            if (gap && (i % 3 == 1)) begin
                valid_extrinsic = 1'b0;
                extrinsic = 16'h1234;
                step();
            end
            valid_extrinsic = 1'b1;
            extrinsic = din[i];
            step();
        end
        valid_extrinsic = 1'b0;
    endtask

    task automatic run_frame(input int k, input int a, input int b, input logic m,
                             input logic stall, input logic gap, input logic noise);
        int nvalid;
        int c;
        load_frame(k, a, b, m, gap, noise, k);
        if (!stall) begin
            chk("latency_c1", valid_apriori, 0);
            step();
            chk("latency_c2", valid_apriori, 0);
            step();
            chk("latency_c3", valid_apriori, 1);
        end
        nvalid = 0;
        c = 0;
        while (busy && c < 4 * k + 50) begin
            if (stall) apriori_ready = 1'($urandom_range(0, 1));
            if (noise) begin
                valid_extrinsic = 1'b1;
                extrinsic = 16'hdead;
                valid_blklen = 1'b1;
                blklen = 16'd48;
                f1 = 16'd7;
                f2 = 16'd12;
                mode = ~m;
            end
            if (valid_apriori) nvalid++;
            step();
            c++;
        end
        valid_extrinsic = 1'b0;
        valid_blklen = 1'b0;
        apriori_ready = 1'b1;
        chk("drain_busy_fall", busy, 0);
        chk("all_outputs_seen", exp_q.size(), 0);
        chk("out_count", out_log.size(), k);
        if (!stall) chk("throughput", nvalid, k);
        chk("idle_valid", valid_apriori, 0);
        chk("idle_last", apriori_last, 0);
        step();
        chk("no_restart", busy, 0);
    endtask

    task automatic bad_cfg(input int k, input int a, input int b);
        blklen = 16'(k);
        f1 = 16'(a);
        f2 = 16'(b);
        mode = 1'b0;
        valid_blklen = 1'b1;
        step();
        valid_blklen = 1'b0;
        chk("bad_cfg_err", cfg_err, 1);
        chk("bad_cfg_busy", busy, 0);
        step();
        chk("bad_cfg_busy_after", busy, 0);
    endtask

    initial begin
        int dups;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // Frame A: K=40 interleave of a ramp.
        for (int i = 0; i < 40; i++) din[i] = 16'(i);
        run_frame(40, 3, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        if (out_log.size() == 40) begin
            chk("k40_out1", out_log[1], 13);
            chk("k40_out2", out_log[2], 6);
            chk("k40_out3", out_log[3], 19);
            chk("k40_out39", out_log[39], 7);
            for (int i = 0; i < 40; i++) din[i] = out_log[i];
        end

        // Frame B: deinterleave frame A's output; must return the ramp.
        run_frame(40, 3, 10, 1'b1, 1'b0, 1'b1, 1'b0);
        if (out_log.size() == 40) begin
            for (int j = 0; j < 40; j++) chk("roundtrip", out_log[j], j);
        end

        // Frame C: signed data, random stalls, ignored strobes while busy.
        for (int i = 0; i < 40; i++) din[i] = 16'(i * 1237 + 45536);
        run_frame(40, 3, 10, 1'b0, 1'b1, 1'b0, 1'b1);

        bad_cfg(6152, 3, 10);
        bad_cfg(44, 3, 10);
        bad_cfg(40, 40, 10);
        bad_cfg(0, 0, 0);
        for (int i = 0; i < 48; i++) din[i] = 16'(16'hff00 + i * 3);
        run_frame(48, 7, 12, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-LOAD, then mid-DRAIN, then a clean frame.
        for (int i = 0; i < 40; i++) din[i] = 16'(500 + i);
        load_frame(40, 3, 10, 1'b0, 1'b0, 1'b0, 20);
        do_reset("rst_load");
        load_frame(40, 3, 10, 1'b0, 1'b0, 1'b0, 40);
        repeat (10) step();
        do_reset("rst_drain");
        run_frame(40, 3, 10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Largest block.
        for (int i = 0; i < 6144; i++) din[i] = 16'(i);
        run_frame(6144, 263, 480, 1'b0, 1'b0, 1'b0, 1'b0);
        if (out_log.size() == 6144) begin
            chk("k6144_out1", out_log[1], 743);
            chk("k6144_out2", out_log[2], 2446);
            for (int i = 0; i < 6144; i++) seen[i] = 1'b0;
            dups = 0;
            foreach (out_log[i]) begin
                if (out_log[i] >= 16'd6144) dups++;
                else if (seen[out_log[i]]) dups++;
                else seen[out_log[i]] = 1'b1;
            end
            chk("k6144_distinct", dups, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
